multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I core. A Moore FSM sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It drives the shared ALU, memory-address mux, instruction register and register file, and selects the immediate format (`ImmSrc`) for the immediate extender. Combinational decode produces `ImmSrc` and `ALUControl`; everything else comes from the state register.

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 116 +++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALUOp/ALUControl/ImmSrc codes and the packed control word of the output ROM.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Shared with the immediate extender.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// (slave): instruction fields and ALU flag in, mux selects and strobes out.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: (ALUOp, funct3, funct7b5, op[5]) -> ALUControl.
// Also used by the single-cycle core.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // op[5] separates R-type sub from addi with Instr[30] set.
                    3'b000:  o_alu_control = (i_funct7b5 & i_op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle RV32I core: state register, next-state
// logic, per-state output ROM, ImmSrc decode and the ALU decoder.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus,
    output state_t                  o_dbg_state
);

    state_t     r_state;
    state_t     w_next_state;
    ctrl_t      w_ctrl;
    logic [2:0] w_alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        w_ctrl       = '0;
        case (r_state)
            FETCH: begin
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.alu_src_b  = 2'b10;
                w_ctrl.result_src = 2'b10;
                w_ctrl.pc_update  = 1'b1;
                w_next_state      = DECODE;
            end
            DECODE: begin
                // ALU precomputes OldPC + ImmExt as the branch target.
                w_ctrl.alu_src_a = 2'b01;
                w_ctrl.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_R:         w_next_state = EXECR;
                    OP_I:         w_next_state = EXECI;
                    OP_JAL:       w_next_state = JAL;
                    OP_BEQ:       w_next_state = BEQ;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_next_state   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_src_b = 2'b01;
                w_next_state     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                w_ctrl.adr_src = 1'b1;
                w_next_state   = MEMWB;
            end
            MEMWB: begin
                w_ctrl.result_src = 2'b01;
                w_ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                w_ctrl.adr_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            EXECR: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = ALUWB;
            end
            EXECI: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_src_b = 2'b01;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = ALUWB;
            end
            JAL: begin
                w_ctrl.alu_src_a = 2'b01;
                w_ctrl.alu_src_b = 2'b10;
                w_ctrl.pc_update = 1'b1;
                w_next_state     = ALUWB;
            end
            ALUWB: begin
                w_ctrl.reg_write = 1'b1;
            end
            BEQ: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_op    = ALUOP_SUB;
                w_ctrl.branch    = 1'b1;
            end
            default: w_next_state = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_ctrl.alu_op),
        .i_funct3      (bus.funct3),
        .i_funct7b5    (bus.funct7b5),
        .i_op5         (bus.op[5]),
        .o_alu_control (w_alu_control)
    );

    assign bus.ImmSrc     = imm_src_of(bus.op);
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.ResultSrc  = w_ctrl.result_src;
    assign bus.AdrSrc     = w_ctrl.adr_src;
    assign bus.ALUControl = w_alu_control;
    assign bus.IRWrite    = w_ctrl.ir_write;
    assign bus.PCWrite    = w_ctrl.pc_update | (w_ctrl.branch & bus.Zero);
    assign bus.RegWrite   = w_ctrl.reg_write;
    assign bus.MemWrite   = w_ctrl.mem_write;
    assign bus.Illegal    = w_ctrl.illegal;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words
// are queued as each instruction is driven and popped at every negedge.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     n_assert;
    int     n_fail;

    logic [20:0] exp_q[$];
    string       tag_q[$];
    logic [20:0] obs;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word: state, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    // ALUControl, IRWrite, PCWrite, RegWrite, MemWrite, Illegal.
    assign obs = {dbg_state, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                  bus.AdrSrc, bus.ALUControl, bus.IRWrite, bus.PCWrite,
                  bus.RegWrite, bus.MemWrite, bus.Illegal};

    function automatic logic [20:0] mk(input logic [3:0] st, input logic [1:0] imm,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic adr,
                                       input logic [2:0] aluc, input logic irw,
                                       input logic pcw, input logic rw,
                                       input logic mw, input logic ill);
        return {st, imm, a, b, rs, adr, aluc, irw, pcw, rw, mw, ill};
    endfunction

    function automatic logic [20:0] v_fetch(input logic [1:0] imm);
        return mk(FETCH, imm, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] v_decode(input logic [1:0] imm, input logic ill);
        return mk(DECODE, imm, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, ill);
    endfunction

    function automatic logic [20:0] v_aluwb(input logic [1:0] imm);
        return mk(ALUWB, imm, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    task automatic push(input string tag, input logic [20:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_one();
        logic [20:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    // Queue length bounds the number of cycles waited.
    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_one();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(OP_LW, 3'b010, 1'b0, 1'b0);

        push("rst_hold", v_fetch(IMM_I));
        drain();
        reset = 1'b0;

        // lw: 5 cycles
        push("lw_fetch",   v_fetch(IMM_I));
        push("lw_decode",  v_decode(IMM_I, 1'b0));
        push("lw_memadr",  mk(MEMADR, IMM_I, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("lw_memread", mk(MEMREAD, IMM_I, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("lw_memwb",   mk(MEMWB, IMM_I, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        drain();

        // sw: 4 cycles
        drive(OP_SW, 3'b010, 1'b0, 1'b0);
        push("sw_fetch",    v_fetch(IMM_S));
        push("sw_decode",   v_decode(IMM_S, 1'b0));
        push("sw_memadr",   mk(MEMADR, IMM_S, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("sw_memwrite", mk(MEMWRITE, IMM_S, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drain();

        // R-type sub
        drive(OP_R, 3'b000, 1'b1, 1'b0);
        push("sub_fetch",  v_fetch(IMM_I));
        push("sub_decode", v_decode(IMM_I, 1'b0));
        push("sub_execr",  mk(EXECR, IMM_I, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("sub_aluwb",  v_aluwb(IMM_I));
        drain();

        // addi with Instr[30]=1 stays add
        drive(OP_I, 3'b000, 1'b1, 1'b0);
        push("addi_fetch",  v_fetch(IMM_I));
        push("addi_decode", v_decode(IMM_I, 1'b0));
        push("addi_execi",  mk(EXECI, IMM_I, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("addi_aluwb",  v_aluwb(IMM_I));
        drain();

        // R-type and / or, I-type slti
        drive(OP_R, 3'b111, 1'b0, 1'b0);
        push("and_fetch",  v_fetch(IMM_I));
        push("and_decode", v_decode(IMM_I, 1'b0));
        push("and_execr",  mk(EXECR, IMM_I, 2'b10, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("and_aluwb",  v_aluwb(IMM_I));
        drain();

        drive(OP_R, 3'b110, 1'b0, 1'b0);
        push("or_fetch",  v_fetch(IMM_I));
        push("or_decode", v_decode(IMM_I, 1'b0));
        push("or_execr",  mk(EXECR, IMM_I, 2'b10, 2'b00, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("or_aluwb",  v_aluwb(IMM_I));
        drain();

        drive(OP_I, 3'b010, 1'($urandom_range(0, 1)), 1'b0);
        push("slti_fetch",  v_fetch(IMM_I));
        push("slti_decode", v_decode(IMM_I, 1'b0));
        push("slti_execi",  mk(EXECI, IMM_I, 2'b10, 2'b01, 2'b00, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("slti_aluwb",  v_aluwb(IMM_I));
        drain();

        // beq taken: 3 cycles
        drive(OP_BEQ, 3'b000, 1'b0, 1'b1);
        push("beq1_fetch",  v_fetch(IMM_B));
        push("beq1_decode", v_decode(IMM_B, 1'b0));
        push("beq1_beq",    mk(BEQ, IMM_B, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        drain();

        // beq not taken
        drive(OP_BEQ, 3'b000, 1'b0, 1'b0);
        push("beq0_fetch",  v_fetch(IMM_B));
        push("beq0_decode", v_decode(IMM_B, 1'b0));
        push("beq0_beq",    mk(BEQ, IMM_B, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // jal: 4 cycles
        drive(OP_JAL, 3'b000, 1'b0, 1'b0);
        push("jal_fetch",  v_fetch(IMM_J));
        push("jal_decode", v_decode(IMM_J, 1'b0));
        push("jal_jal",    mk(JAL, IMM_J, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push("jal_aluwb",  v_aluwb(IMM_J));
        drain();

        // illegal opcodes: 2 cycles each
        drive(7'b0000000, 3'b000, 1'b0, 1'b0);
        push("ill0_fetch",  v_fetch(IMM_I));
        push("ill0_decode", v_decode(IMM_I, 1'b1));
        drain();

        drive(7'b0110111, 3'b000, 1'b0, 1'b0);
        push("ill1_fetch",  v_fetch(IMM_I));
        push("ill1_decode", v_decode(IMM_I, 1'b1));
        drain();

        // lw aborted by reset in MEMREAD
        drive(OP_LW, 3'b010, 1'b0, 1'b0);
        push("ab_fetch",  v_fetch(IMM_I));
        push("ab_decode", v_decode(IMM_I, 1'b0));
        push("ab_memadr", mk(MEMADR, IMM_I, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();
        reset = 1'b1;
        #1;
        push("ab_rst_async", v_fetch(IMM_I));
        compare_one();
        reset = 1'b0;
        #1;
        push("ab_rst_release", v_fetch(IMM_I));
        compare_one();
        @(posedge clk);
        #1;
        push("ab_re_decode",  v_decode(IMM_I, 1'b0));
        push("ab_re_memadr",  mk(MEMADR, IMM_I, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("ab_re_memread", mk(MEMREAD, IMM_I, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("ab_re_memwb",   mk(MEMWB, IMM_I, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push("ab_end_fetch",  v_fetch(IMM_I));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
